main_load_ctrl: RTL and testbench
=================================

// Module: main_load_ctrl
// PURPOSE
//  Parametrised successor of the fixed 7-cycle main buffer. Accepts a packed word stream
//  under valid/ready, unpacks it into a KxK IFM window, a KxK weight set and one bias, then
//  presents them to the PE array under valid/ready. Adds a weight-keep mode that skips the
//  weight phase and reuses the held weights. Sits between the external loader and the PE/MAC array.
// PARAMETERS
//  INPUT_WIDTH   32  stream word width; must be a multiple of OUTPUT_WIDTH (elaboration assert)
//  OUTPUT_WIDTH  8   element width (IFM and WGT), signed
//  KERNEL        3   kernel side; NUM_OF_OUTPUTS = KERNEL*KERNEL (localparam)
//  BIAS_WIDTH    8   bias width, <= INPUT_WIDTH (elaboration assert), signed
//  Localparams: PACK = INPUT_WIDTH/OUTPUT_WIDTH; WORDS = ceil(NUM_OF_OUTPUTS/PACK) (3 by default)
// PORTS
//  clk              in   1                   clock
//  rst_n            in   1                   async active-low reset
//  start            in   1                   begin a load set (honoured only in IDLE, or FULL on handoff)
//  wgt_keep         in   1                   sampled with accepted start: 1 = skip weight phase
//  in_data          in   INPUT_WIDTH         packed stream word
//  in_valid         in   1                   in_data valid
//  in_ready         out  1                   block accepts word this cycle
//  main_output_ifm  out  OUTPUT_WIDTH x N    IFM window, unpacked array [NUM_OF_OUTPUTS-1:0]
//  main_output_wgt  out  OUTPUT_WIDTH x N    weights, unpacked array [NUM_OF_OUTPUTS-1:0]
//  main_output_bias out  BIAS_WIDTH          bias
//  out_valid        out  1                   full set presented
//  out_ready        in   1                   consumer takes the set
//  busy             out  1                   state != IDLE
//  wgt_loaded       out  1                   a complete weight set has been loaded since reset
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst_n asynchronous, active-low. On reset: state IDLE,
//   all output arrays and bias 0, out_valid 0, in_ready 0, wgt_loaded 0, word counter 0, keep flag 0.
//  States: IDLE -> LOAD_IFM -> LOAD_WGT -> LOAD_BIAS -> FULL -> IDLE.
//   IDLE: start=1 -> LOAD_IFM; latch keep = wgt_keep & wgt_loaded (keep ignored if no weights yet).
//   LOAD_IFM: after WORDS accepted words -> LOAD_WGT, or LOAD_BIAS if keep=1.
//   LOAD_WGT: after WORDS accepted words -> LOAD_BIAS; wgt_loaded set on last word.
//   LOAD_BIAS: one accepted word -> FULL.
//   FULL: out_valid=1; on out_valid&out_ready -> IDLE, or LOAD_IFM directly if start=1 same cycle
//    (keep re-latched from wgt_keep that cycle).
//  Handshake: in_ready = 1 exactly in LOAD_* states (registered from state, no comb path from in_valid).
//   Word accepted iff in_valid & in_ready; no acceptance in IDLE/FULL. in_valid low stalls, no timeout.
//  Unpacking: accepted word w (0-based within phase), lane l -> element w*PACK+l,
//   lane l = in_data[l*OUTPUT_WIDTH +: OUTPUT_WIDTH]. Lanes with index >= NUM_OF_OUTPUTS in the
//   last word are discarded (default: word 2 uses lane 0 only). Bias = in_data[BIAS_WIDTH-1:0].
//  Outputs are written in place on accepted words, visible next cycle; held otherwise. Contents are
//   only guaranteed coherent while out_valid=1. With keep=1 main_output_wgt is never written.
//  Latency: minimum set = 2*WORDS+1 accepted words (7 default) + 1 cycle to out_valid;
//   back-to-back sets at 1 word/cycle achieve 8 cycles/set with start held at handoff.
//  start in LOAD_* states ignored; wgt_keep sampled only with an accepted start.
//  Reset mid-load: everything returns to reset values immediately, partial data discarded, wgt_loaded 0.
//  out_ready while out_valid=0 has no effect.
// TESTING
//  1 Reset, start, 7 words 0x04030201,0x08070605,0x00000009,0x14131211,0x18171615,0x00000019,0x0000007F
//    -> ifm[0..8]=1..9, wgt[0..8]=0x11..0x19, bias=0x7F, out_valid 1 cycle after 7th word.
//  2 Same, then start+wgt_keep=1 with 4 words (IFM 3 + bias 1) -> wgt unchanged 0x11..0x19,
//    FULL after 4th word; in_ready low in IDLE/FULL.
//  3 wgt_keep=1 on first start after reset -> keep ignored, 7 words required, wgt_loaded rises on 6th.
//  4 Random in_valid gaps and out_ready held low 5 cycles -> no word lost/duplicated, outputs stable,
//    in_ready 0 throughout FULL; start asserted at handoff -> LOAD_IFM next cycle.
//  5 rst_n pulsed low after 4th word -> all outputs 0, out_valid 0, next set loads correctly from word 0.
//  6 Negative data 0xFF80FE81 in IFM word 0 -> ifm[0]=-127, ifm[1]=-2, ifm[2]=-128, ifm[3]=-1.

Source files
------------

// File: rtl/main_load_ctrl.sv
// Unpacks a valid/ready word stream into a KxK IFM window, KxK weights and a bias; optional weight reuse.
// Latency: 2*WORDS+1 words (WORDS+1 with keep) then out_valid next cycle; in_ready only in LOAD_*, set held until out_ready.
module main_load_ctrl #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int KERNEL       = 3,
  parameter int BIAS_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           wgt_keep,
  input  logic [INPUT_WIDTH-1:0]         in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic signed [OUTPUT_WIDTH-1:0] main_output_ifm [KERNEL*KERNEL-1:0],
  output logic signed [OUTPUT_WIDTH-1:0] main_output_wgt [KERNEL*KERNEL-1:0],
  output logic signed [BIAS_WIDTH-1:0]   main_output_bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           wgt_loaded
);

  localparam int NUM_OF_OUTPUTS = KERNEL * KERNEL;
  localparam int PACK           = INPUT_WIDTH / OUTPUT_WIDTH;
  localparam int WORDS          = (NUM_OF_OUTPUTS + PACK - 1) / PACK;
  localparam int CW             = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (INPUT_WIDTH % OUTPUT_WIDTH != 0) begin : g_bad_pack
    $error("INPUT_WIDTH must be a multiple of OUTPUT_WIDTH");
  end
  if (BIAS_WIDTH > INPUT_WIDTH) begin : g_bad_bias
    $error("BIAS_WIDTH must not exceed INPUT_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IFM  = 3'd1,
    LOAD_WGT  = 3'd2,
    LOAD_BIAS = 3'd3,
    FULL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            keep_q, keep_d;
  logic            loaded_d;
  logic            accept;
  logic            last_word;

  assign accept    = in_valid & in_ready;
  assign last_word = (cnt_q == CW'(WORDS - 1));
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    keep_d   = keep_q;
    loaded_d = wgt_loaded;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_IFM;
          cnt_d   = '0;
          keep_d  = wgt_keep & wgt_loaded;
        end
      end
      LOAD_IFM: begin
        if (accept) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = keep_q ? LOAD_BIAS : LOAD_WGT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_WGT: begin
        if (accept) begin
          if (last_word) begin
            cnt_d    = '0;
            state_d  = LOAD_BIAS;
            loaded_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_BIAS: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        // Handoff with start held skips IDLE so sets can stream back to back.
        if (out_ready) begin
          if (start) begin
            state_d = LOAD_IFM;
            cnt_d   = '0;
            keep_d  = wgt_keep & wgt_loaded;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      keep_q     <= 1'b0;
      wgt_loaded <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      keep_q     <= keep_d;
      wgt_loaded <= loaded_d;
      in_ready   <= (state_d == LOAD_IFM) || (state_d == LOAD_WGT) || (state_d == LOAD_BIAS);
      out_valid  <= (state_d == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_OF_OUTPUTS; e++) begin
        main_output_ifm[e] <= '0;
        main_output_wgt[e] <= '0;
      end
      main_output_bias <= '0;
    end else if (accept) begin
      case (state_q)
        LOAD_IFM: begin
          for (int e = 0; e < NUM_OF_OUTPUTS; e++) begin
            if (CW'(e / PACK) == cnt_q)
              main_output_ifm[e] <= in_data[(e % PACK)*OUTPUT_WIDTH +: OUTPUT_WIDTH];
          end
        end
        LOAD_WGT: begin
          for (int e = 0; e < NUM_OF_OUTPUTS; e++) begin
            if (CW'(e / PACK) == cnt_q)
              main_output_wgt[e] <= in_data[(e % PACK)*OUTPUT_WIDTH +: OUTPUT_WIDTH];
          end
        end
        LOAD_BIAS: main_output_bias <= in_data[BIAS_WIDTH-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_load_ctrl.sv
// Directed bench for main_load_ctrl: full loads, weight-keep, stalls/backpressure, handoff, mid-load reset, signed lanes.
module tb_main_load_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              wgt_keep;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] ifm [8:0];
  logic signed [7:0] wgt [8:0];
  logic signed [7:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              wgt_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] set1 [7] = '{32'h04030201, 32'h08070605, 32'h00000009,
                            32'h14131211, 32'h18171615, 32'h00000019, 32'h0000007F};
  logic [31:0] set2 [4] = '{32'h24232221, 32'h28272625, 32'h00000029, 32'h00000055};
  logic [31:0] set3 [7] = '{32'h34333231, 32'h38373635, 32'h00000039,
                            32'h44434241, 32'h48474645, 32'h00000049, 32'h0000000A};
  logic [31:0] set6 [7] = '{32'hFF80FE81, 32'h08070605, 32'h00000009,
                            32'h14131211, 32'h18171615, 32'h00000019, 32'h00000080};

  always #5 clk = ~clk;

  main_load_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .wgt_keep         (wgt_keep),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .main_output_ifm  (ifm),
    .main_output_wgt  (wgt),
    .main_output_bias (bias),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .wgt_loaded       (wgt_loaded)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_set(input string tag, input int ifm_base, input int wgt_base, input int b);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s_ifm%0d", tag, i), int'(ifm[i]), ifm_base + i);
      check($sformatf("%s_wgt%0d", tag, i), int'(wgt[i]), wgt_base + i);
    end
    check({tag, "_bias"}, int'(bias), b);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic send_word(input logic [31:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic k);
    start    = 1'b1;
    wgt_keep = k;
    @(posedge clk); #1;
    start    = 1'b0;
    wgt_keep = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wgt_keep = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wgt_loaded", int'(wgt_loaded), 0);
    check("rst_ifm0", int'(ifm[0]), 0);
    check("rst_bias", int'(bias), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First start with keep requested: no weights yet, so all 7 words are needed.
    do_start(1'b1);
    check("t1_in_ready_load", int'(in_ready), 1);
    for (int i = 0; i < 7; i++) begin
      send_word(set1[i]);
      if (i == 4) check("t3_loaded_before_6th", int'(wgt_loaded), 0);
      if (i == 5) begin
        check("t3_loaded_after_6th", int'(wgt_loaded), 1);
        check("t3_not_full_after_6th", int'(out_valid), 0);
      end
    end
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_in_ready_full", int'(in_ready), 0);
    check_set("t1", 1, 'h11, 'h7F);
    consume();
    check("t1_idle_out_valid", int'(out_valid), 0);
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_in_ready", int'(in_ready), 0);

    // Weight-keep set: IFM + bias only.
    do_start(1'b1);
    for (int i = 0; i < 3; i++) send_word(set2[i]);
    check("t2_bias_phase_ready", int'(in_ready), 1);
    check("t2_bias_phase_valid", int'(out_valid), 0);
    send_word(set2[3]);
    check("t2_out_valid", int'(out_valid), 1);
    check("t2_in_ready_full", int'(in_ready), 0);
    check_set("t2", 'h21, 'h11, 'h55);

    // Backpressure: hold FULL for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("t4_hold%0d_in_ready", c), int'(in_ready), 0);
      check($sformatf("t4_hold%0d_valid", c), int'(out_valid), 1);
      check($sformatf("t4_hold%0d_ifm8", c), int'(ifm[8]), 'h29);
    end
    start = 1'b1; wgt_keep = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    check("t4_handoff_busy", int'(busy), 1);
    check("t4_handoff_ready", int'(in_ready), 1);
    check("t4_handoff_valid", int'(out_valid), 0);
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send_word(set3[i]);
    end
    check("t4_out_valid", int'(out_valid), 1);
    check_set("t4", 'h31, 'h41, 'h0A);
    consume();

    // Reset in the middle of a load.
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send_word(set1[i]);
    rst_n = 1'b0;
    #2;
    check("t5_rst_out_valid", int'(out_valid), 0);
    check("t5_rst_in_ready", int'(in_ready), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_loaded", int'(wgt_loaded), 0);
    check("t5_rst_ifm0", int'(ifm[0]), 0);
    check("t5_rst_wgt0", int'(wgt[0]), 0);
    check("t5_rst_bias", int'(bias), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh set with negative lanes.
    do_start(1'b0);
    for (int i = 0; i < 7; i++) send_word(set6[i]);
    check("t6_out_valid", int'(out_valid), 1);
    check("t6_ifm0", int'(ifm[0]), -127);
    check("t6_ifm1", int'(ifm[1]), -2);
    check("t6_ifm2", int'(ifm[2]), -128);
    check("t6_ifm3", int'(ifm[3]), -1);
    for (int i = 4; i < 9; i++) check($sformatf("t6_ifm%0d", i), int'(ifm[i]), i + 1);
    for (int i = 0; i < 9; i++) check($sformatf("t6_wgt%0d", i), int'(wgt[i]), 'h11 + i);
    check("t6_bias", int'(bias), -128);
    check("t6_loaded", int'(wgt_loaded), 1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
